// File: rtl/seg_pkg.sv
// seg_pkg: register map, CTRL bit positions and hex-to-segment table for the scan controller
package seg_pkg;
  localparam logic [31:0] ADDR_VER        = 32'h00;
  localparam logic [31:0] ADDR_CTRL       = 32'h04;
  localparam logic [31:0] ADDR_DIV        = 32'h08;
  localparam logic [31:0] ADDR_DIGIT_BASE = 32'h10;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_DEC     = 1;
  localparam int CTRL_SEG_INV = 2;
  localparam int CTRL_DIG_INV = 3;
  // active-high {g,f,e,d,c,b,a} for 0-F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational nibble to seven-segment pattern
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: register-mapped multiplexed seven-segment display scanner
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int          NUM_DIGITS   = 4,
  parameter int          DIV_W        = 16,
  parameter int          BLANK_CYCLES = 2,
  parameter logic [31:0] HW_VER       = 32'h02
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr,
  input  logic [31:0]           waddr,
  input  logic [31:0]           wdata,
  input  logic                  rd,
  input  logic [31:0]           raddr,
  output logic [31:0]           rdata,
  output logic [7:0]            seg_pin,
  output logic [NUM_DIGITS-1:0] dig_pin
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W:0] BLANK = (DIV_W+1)'(BLANK_CYCLES);
  logic [3:0]            ctrl_q;
  logic [DIV_W-1:0]      div_q, cnt_q, cnt_d;
  logic [7:0]            digit_q [NUM_DIGITS];
  logic [IW-1:0]         idx_q, idx_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [7:0]            seg_q, seg_d, raw;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [6:0]            hex;
  logic                  en, blank, wrap;
  logic                  unused_wdata;
  assign en           = ctrl_q[CTRL_EN];
  assign raw          = digit_q[idx_q];
  assign unused_wdata = ^wdata;
  assign rdata        = rdata_q;
  assign seg_pin      = seg_q;
  assign dig_pin      = dig_q;
  seg_hex_decode u_dec (.nib_i(raw[3:0]), .seg_o(hex));
  // >= rather than == so a DIV shrunk below the running count wraps at once
  always_comb begin
    wrap  = cnt_q >= div_q;
    cnt_d = en && !wrap ? cnt_q + DIV_W'(1) : '0;
    idx_d = !en ? '0 : !wrap ? idx_q : idx_q == IW'(NUM_DIGITS-1) ? '0 : idx_q + IW'(1);
    blank = {1'b0, cnt_q} < BLANK;
    seg_d = (en ? (ctrl_q[CTRL_DEC] ? {raw[7], hex} : raw) : 8'h00) ^ {8{ctrl_q[CTRL_SEG_INV]}};
    dig_d = (en && !blank ? NUM_DIGITS'(1) << idx_q : '0) ^ {NUM_DIGITS{ctrl_q[CTRL_DIG_INV]}};
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      if (raddr == ADDR_VER)  rdata_d = HW_VER;
      if (raddr == ADDR_CTRL) rdata_d = {28'h0, ctrl_q};
      if (raddr == ADDR_DIV)  rdata_d = 32'(div_q);
      for (int i = 0; i < NUM_DIGITS; i++)
        if (raddr == ADDR_DIGIT_BASE + 32'(4*i)) rdata_d = {24'h0, digit_q[i]};
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      if (wr && waddr == ADDR_CTRL) ctrl_q <= wdata[3:0];
      if (wr && waddr == ADDR_DIV)  div_q  <= wdata[DIV_W-1:0];
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr && waddr == ADDR_DIGIT_BASE + 32'(4*i)) digit_q[i] <= wdata[7:0];
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scoreboard bench for the seven-segment scan controller
module tb_seg_scan_ctrl;
  import seg_pkg::*;
  logic        clk = 0, rstn = 0, wr = 0, rd = 0;
  logic [31:0] waddr = 0, wdata = 0, raddr = 0, rdata;
  logic [7:0]  seg_pin;
  logic [3:0]  dig_pin;
  logic [11:0] pq[$];
  logic [31:0] rq[$];
  logic [11:0] mp;
  logic [31:0] me;
  logic        rd_seen = 0;
  int          tests = 0, fails = 0;
  string       phase = "reset";
  // expected {seg[7:0], dig[3:0]} per cycle, first entry is the output of the CTRL write edge
  localparam logic [11:0] SCAN [21] = '{12'h000,
    12'h3F0, 12'h3F0, 12'h3F1, 12'h3F1, 12'h060, 12'h060, 12'h062, 12'h062,
    12'h000, 12'h000, 12'h004, 12'h004, 12'h000, 12'h000, 12'h008, 12'h008,
    12'h3F0, 12'h3F0, 12'h3F1, 12'h3F1};
  localparam logic [11:0] DECT [17] = '{12'h000,
    12'h710, 12'h710, 12'h711, 12'h711, 12'h7D0, 12'h7D0, 12'h7D2, 12'h7D2,
    12'hF70, 12'hF70, 12'hF74, 12'hF74, 12'h3F0, 12'h3F0, 12'h3F8, 12'h3F8};
  localparam logic [11:0] POL [17] = '{12'h000,
    12'hC0F, 12'hC0F, 12'hC0E, 12'hC0E, 12'hF9F, 12'hF9F, 12'hF9D, 12'hF9D,
    12'h75F, 12'h75F, 12'h75B, 12'h75B, 12'hFFF, 12'hFFF, 12'hFF7, 12'hFF7};
  localparam logic [11:0] DIVT [11] = '{12'h3F1, 12'h3F1, 12'h060, 12'h060,
    12'h8A0, 12'h8A0, 12'h000, 12'h000, 12'h3F0, 12'h3F0, 12'h060};
  localparam logic [11:0] RST [5] = '{12'h000, 12'h3F0, 12'h3F0, 12'h3F1, 12'h3F1};
  always #5 clk = ~clk;
  seg_scan_ctrl #(.NUM_DIGITS(4), .DIV_W(16), .BLANK_CYCLES(2), .HW_VER(32'h02)) dut (
    .clk(clk), .rstn(rstn), .wr(wr), .waddr(waddr), .wdata(wdata),
    .rd(rd), .raddr(raddr), .rdata(rdata), .seg_pin(seg_pin), .dig_pin(dig_pin));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) rd_seen <= rd;
  always @(negedge clk) begin
    if (rd_seen && rq.size() != 0) begin
      me = rq.pop_front();
      chk({phase, " rdata"}, rdata, me);
    end
    if (pq.size() != 0) begin
      mp = pq.pop_front();
      chk({phase, " seg_pin"}, 32'(seg_pin), 32'(mp[11:4]));
      chk({phase, " dig_pin"}, 32'(dig_pin), 32'(mp[3:0]));
    end
  end
  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    wr = 1; waddr = a; wdata = d;
    @(posedge clk); #1;
    wr = 0;
  endtask
  task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp);
    rd = 1; raddr = a; rq.push_back(exp);
    @(posedge clk); #1;
    rd = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && (pq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
    if (pq.size() != 0 || rq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s drain: %0d pin and %0d read entries left, 0 required", phase, pq.size(), rq.size());
      pq.delete();
      rq.delete();
    end
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk); #1;
    chk("reset rdata", rdata, 32'h0);
    chk("reset seg_pin", 32'(seg_pin), 32'h0);
    chk("reset dig_pin", 32'(dig_pin), 32'h0);
    rstn = 1;
    @(posedge clk); #1;
    rd_reg(ADDR_VER, 32'h2);
    phase = "scan";
    wr_reg(ADDR_DIGIT_BASE, 32'h3F);
    wr_reg(ADDR_DIGIT_BASE + 4, 32'h06);
    wr_reg(ADDR_DIV, 32'd3);
    wr_reg(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 21; i++) pq.push_back(SCAN[i]);
    drain();
    phase = "decode";
    wr_reg(ADDR_DIGIT_BASE + 8, 32'h8A);
    wr_reg(ADDR_CTRL, 32'h0);
    wr_reg(ADDR_CTRL, 32'h3);
    for (int i = 0; i < 17; i++) pq.push_back(DECT[i]);
    drain();
    phase = "polarity";
    wr_reg(ADDR_CTRL, 32'h0);
    wr_reg(ADDR_CTRL, 32'hD);
    for (int i = 0; i < 17; i++) pq.push_back(POL[i]);
    drain();
    phase = "en_off";
    wr_reg(ADDR_CTRL, 32'hC);
    @(posedge clk); #1;
    pq.push_back(12'hFFF);
    pq.push_back(12'hFFF);
    drain();
    phase = "div_wrap";
    wr_reg(ADDR_CTRL, 32'h0);
    wr_reg(ADDR_CTRL, 32'h1);
    repeat (2) @(posedge clk); #1;
    wr_reg(ADDR_DIV, 32'd1);
    for (int i = 0; i < 11; i++) pq.push_back(DIVT[i]);
    drain();
    phase = "regs";
    wr_reg(ADDR_CTRL, 32'hFF);
    rd_reg(ADDR_CTRL, 32'hF);
    wr_reg(ADDR_DIV, 32'h12345);
    rd_reg(ADDR_DIV, 32'h2345);
    wr_reg(32'h0C, 32'hFFFF);
    rd_reg(32'h0C, 32'h0);
    rd_reg(32'h20, 32'h0);
    wr = 1; waddr = ADDR_DIGIT_BASE; wdata = 32'h55;
    rd = 1; raddr = ADDR_DIGIT_BASE; rq.push_back(32'h3F);
    @(posedge clk); #1;
    wr = 0; rd = 0;
    rd_reg(ADDR_DIGIT_BASE, 32'h55);
    rd_reg(ADDR_DIGIT_BASE + 12, 32'h0);
    rd_reg(ADDR_DIGIT_BASE + 8, 32'h8A);
    drain();
    phase = "async_rst";
    wr_reg(ADDR_CTRL, 32'h0);
    wr_reg(ADDR_DIV, 32'd3);
    wr_reg(ADDR_CTRL, 32'h1);
    repeat (11) @(posedge clk); #1;
    chk("pre-reset seg_pin", 32'(seg_pin), 32'h8A);
    chk("pre-reset dig_pin", 32'(dig_pin), 32'h4);
    #2 rstn = 0;
    #1;
    chk("async seg_pin", 32'(seg_pin), 32'h0);
    chk("async dig_pin", 32'(dig_pin), 32'h0);
    chk("async rdata", rdata, 32'h0);
    @(negedge clk) rstn = 1;
    repeat (3) @(posedge clk); #1;
    chk("post-reset seg_pin", 32'(seg_pin), 32'h0);
    chk("post-reset dig_pin", 32'(dig_pin), 32'h0);
    phase = "restart";
    wr_reg(ADDR_DIGIT_BASE, 32'h3F);
    wr_reg(ADDR_DIV, 32'd3);
    wr_reg(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) pq.push_back(RST[i]);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end
endmodule
